// File: rtl/dds_key_pkg.sv
// dds_key_pkg: shared constants and types for the DDS key controller.
//   Key indices : KEY_SEL, KEY_FUP, KEY_FDN, KEY_PH (NUM_KEYS total)
//   Widths      : FREQ_W (frequency word), PHASE_W (phase offset)
//   Types       : rpt_state_t, the per-key auto-repeat state
//                 (used only when AUTO_REPEAT_EN is defined)
package dds_key_pkg;

  localparam int KEY_SEL  = 0;
  localparam int KEY_FUP  = 1;
  localparam int KEY_FDN  = 2;
  localparam int KEY_PH   = 3;
  localparam int NUM_KEYS = 4;

  localparam int FREQ_W  = 7;
  localparam int PHASE_W = 5;

  typedef enum logic [1:0] {
    RPT_IDLE   = 2'd0,
    RPT_WAIT   = 2'd1,
    RPT_REPEAT = 2'd2
  } rpt_state_t;

endpackage

// File: rtl/dds_key_ctrl_key_filter.sv
// key_filter: conditioning for one raw active-low push-key.
//   Contains a 2-FF synchroniser, a saturating debounce counter and, when
//   AUTO_REPEAT_EN is defined, an auto-repeat FSM (enabled per instance by
//   RPT_EN).
// Ports:
//   sys_clk    in   system clock (rising edge)
//   sys_rst_n  in   synchronous active-low reset
//   key_n      in   raw key, asynchronous, 0 = pressed
//   press_evt  out  1-cycle event: debounced press or auto-repeat tick
// Macro: AUTO_REPEAT_EN adds the repeat FSM; without it the block emits
//   exactly one event per press.
//
// Repeat FSM states
//   state      | meaning
//   RPT_IDLE   | no qualified press in progress
//   RPT_WAIT   | press accepted, counting the initial hold delay
//   RPT_REPEAT | still held, one event every RPT_PER cycles
module key_filter
  import dds_key_pkg::*;
#(
  parameter logic [19:0] CNT_MAX = 20'd999_999,
  parameter logic [24:0] RPT_DLY = 25'd24_999_999,
  parameter logic [22:0] RPT_PER = 23'd4_999_999,
  parameter bit          RPT_EN  = 1'b0
) (
  input  logic sys_clk,
  input  logic sys_rst_n,
  input  logic key_n,
  output logic press_evt
);

  if (CNT_MAX < 20'd2) begin : g_bad_cnt
    $error("key_filter: CNT_MAX must be at least 2");
  end
  if (RPT_EN && ((RPT_DLY == 25'd0) || (RPT_PER == 23'd0))) begin : g_bad_rpt
    $error("key_filter: repeat delay and period must be non-zero");
  end

  logic        s1_q;
  logic        s2_q;
  logic [1:0]  vld_q;
  logic        armed_q;
  logic        armed_d;
  logic [19:0] cnt_q;
  logic [19:0] cnt_d;
  logic        deb_evt;

  // vld_q marks when s2_q holds a real sample rather than its reset value;
  // only a genuinely sampled release arms the key, so a key held through
  // reset cannot fire until it is let go.
  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      s1_q    <= 1'b1;
      s2_q    <= 1'b1;
      vld_q   <= 2'b00;
      armed_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      s1_q    <= key_n;
      s2_q    <= s1_q;
      vld_q   <= {vld_q[0], 1'b1};
      armed_q <= armed_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if (s2_q) begin
      cnt_d = '0;
    end else if (cnt_q != CNT_MAX) begin
      cnt_d = cnt_q + 20'd1;
    end
    armed_d = armed_q | (vld_q[1] & s2_q);
    deb_evt = armed_q & ~s2_q & (cnt_q == (CNT_MAX - 20'd1));
  end

`ifdef AUTO_REPEAT_EN
  rpt_state_t  st_q;
  rpt_state_t  st_d;
  logic [24:0] tmr_q;
  logic [24:0] tmr_d;
  logic        rpt_evt;

  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      st_q  <= RPT_IDLE;
      tmr_q <= '0;
    end else begin
      st_q  <= st_d;
      tmr_q <= tmr_d;
    end
  end

  // Timer is loaded with interval-1 so the event lands exactly RPT_DLY /
  // RPT_PER cycles after the previous one.
  always_comb begin
    st_d    = st_q;
    tmr_d   = tmr_q;
    rpt_evt = 1'b0;
    if (!RPT_EN || s2_q) begin
      st_d  = RPT_IDLE;
      tmr_d = '0;
    end else begin
      case (st_q)
        RPT_IDLE: begin
          if (deb_evt) begin
            st_d  = RPT_WAIT;
            tmr_d = RPT_DLY - 25'd1;
          end
        end
        RPT_WAIT: begin
          if (tmr_q == '0) begin
            rpt_evt = 1'b1;
            st_d    = RPT_REPEAT;
            tmr_d   = {2'b00, RPT_PER} - 25'd1;
          end else begin
            tmr_d = tmr_q - 25'd1;
          end
        end
        RPT_REPEAT: begin
          if (tmr_q == '0) begin
            rpt_evt = 1'b1;
            tmr_d   = {2'b00, RPT_PER} - 25'd1;
          end else begin
            tmr_d = tmr_q - 25'd1;
          end
        end
        default: begin
          st_d  = RPT_IDLE;
          tmr_d = '0;
        end
      endcase
    end
  end

  assign press_evt = deb_evt | rpt_evt;
`else
  assign press_evt = deb_evt;
`endif

endmodule

// File: rtl/dds_key_ctrl.sv
// dds_key_ctrl: key front end for the DDS core. Debounces four active-low
// push-keys and maintains the waveform select, frequency word and phase
// offset registers that drive the DDS.
// Ports:
//   sys_clk     in   system clock (rising edge)
//   sys_rst_n   in   synchronous active-low reset
//   key_in[3:0] in   raw keys, 0 = pressed: [0] sel toggle, [1] freq up,
//                    [2] freq down, [3] phase step
//   sel         out  waveform select
//   freq[6:0]   out  frequency word, saturating in [FREQ_MIN, FREQ_MAX]
//   phase_ctrl  out  phase offset, wraps modulo 32
//   key_flag    out  1-cycle strobe on every control-register update
// Macro: AUTO_REPEAT_EN enables hold-to-repeat on keys 1..3.
module dds_key_ctrl
  import dds_key_pkg::*;
#(
  parameter logic [19:0]       CNT_MAX    = 20'd999_999,
  parameter logic [FREQ_W-1:0] FREQ_MIN   = 7'd1,
  parameter logic [FREQ_W-1:0] FREQ_MAX   = 7'd100,
  parameter logic [24:0]       REPEAT_DLY = 25'd24_999_999,
  parameter logic [22:0]       REPEAT_PER = 23'd4_999_999
) (
  input  logic                sys_clk,
  input  logic                sys_rst_n,
  input  logic [NUM_KEYS-1:0] key_in,
  output logic                sel,
  output logic [FREQ_W-1:0]   freq,
  output logic [PHASE_W-1:0]  phase_ctrl,
  output logic                key_flag
);

  if (FREQ_MIN > FREQ_MAX) begin : g_bad_freq
    $error("dds_key_ctrl: FREQ_MIN must not exceed FREQ_MAX");
  end

  localparam logic [FREQ_W-1:0]  FREQ_ONE  = 1;
  localparam logic [PHASE_W-1:0] PHASE_ONE = 1;

  logic [NUM_KEYS-1:0] press_evt;

  for (genvar k = 0; k < NUM_KEYS; k++) begin : g_key
    key_filter #(
      .CNT_MAX (CNT_MAX),
      .RPT_DLY (REPEAT_DLY),
      .RPT_PER (REPEAT_PER),
      .RPT_EN  (k != KEY_SEL)
    ) u_filter (
      .sys_clk   (sys_clk),
      .sys_rst_n (sys_rst_n),
      .key_n     (key_in[k]),
      .press_evt (press_evt[k])
    );
  end

  logic               sel_q,   sel_d;
  logic [FREQ_W-1:0]  freq_q,  freq_d;
  logic [PHASE_W-1:0] phase_q, phase_d;
  logic               flag_q,  flag_d;

  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      sel_q   <= 1'b0;
      freq_q  <= FREQ_MIN;
      phase_q <= '0;
      flag_q  <= 1'b0;
    end else begin
      sel_q   <= sel_d;
      freq_q  <= freq_d;
      phase_q <= phase_d;
      flag_q  <= flag_d;
    end
  end

  // Fixed priority, lowest key index wins; losers are dropped, not queued.
  // The flag pulses even when saturation leaves freq unchanged.
  always_comb begin
    sel_d   = sel_q;
    freq_d  = freq_q;
    phase_d = phase_q;
    flag_d  = 1'b0;
    if (press_evt[KEY_SEL]) begin
      sel_d  = ~sel_q;
      flag_d = 1'b1;
    end else if (press_evt[KEY_FUP]) begin
      freq_d = (freq_q == FREQ_MAX) ? FREQ_MAX : freq_q + FREQ_ONE;
      flag_d = 1'b1;
    end else if (press_evt[KEY_FDN]) begin
      freq_d = (freq_q == FREQ_MIN) ? FREQ_MIN : freq_q - FREQ_ONE;
      flag_d = 1'b1;
    end else if (press_evt[KEY_PH]) begin
      phase_d = phase_q + PHASE_ONE;
      flag_d  = 1'b1;
    end
  end

  assign sel        = sel_q;
  assign freq       = freq_q;
  assign phase_ctrl = phase_q;
  assign key_flag   = flag_q;

endmodule

// File: tb/tb_dds_key_ctrl.sv
module tb_dds_key_ctrl;

  localparam logic [19:0] CNT_MAX    = 20'd10;
  localparam logic [6:0]  FREQ_MIN   = 7'd1;
  localparam logic [6:0]  FREQ_MAX   = 7'd100;
  localparam logic [24:0] REPEAT_DLY = 25'd40;
  localparam logic [22:0] REPEAT_PER = 23'd8;
  localparam int          LAT        = 12;   // CNT_MAX + 2

  logic       sys_clk   = 1'b0;
  logic       sys_rst_n = 1'b0;
  logic [3:0] key_in    = 4'hF;
  logic       sel;
  logic [6:0] freq;
  logic [4:0] phase_ctrl;
  logic       key_flag;

  int tests_run    = 0;
  int tests_failed = 0;
  int cyc          = 0;
  int flag_cnt     = 0;
  int flag_cycles[$];

  // behavioural model of the control registers
  int m_sel   = 0;
  int m_freq  = 1;
  int m_phase = 0;

  dds_key_ctrl #(
    .CNT_MAX    (CNT_MAX),
    .FREQ_MIN   (FREQ_MIN),
    .FREQ_MAX   (FREQ_MAX),
    .REPEAT_DLY (REPEAT_DLY),
    .REPEAT_PER (REPEAT_PER)
  ) dut (
    .sys_clk    (sys_clk),
    .sys_rst_n  (sys_rst_n),
    .key_in     (key_in),
    .sel        (sel),
    .freq       (freq),
    .phase_ctrl (phase_ctrl),
    .key_flag   (key_flag)
  );

  always #5 sys_clk = ~sys_clk;

  always @(posedge sys_clk) cyc <= cyc + 1;

  always @(negedge sys_clk) begin
    if (key_flag === 1'b1) begin
      flag_cnt = flag_cnt + 1;
      flag_cycles.push_back(cyc);
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, tests=%0d failed=%0d", tests_run, tests_failed);
    $fatal(1, "watchdog");
  end

  task automatic tick(input int n);
    repeat (n) @(negedge sys_clk);
  endtask

  function automatic void model_reset();
    m_sel   = 0;
    m_freq  = 1;
    m_phase = 0;
  endfunction

  function automatic void model_apply(input int k);
    case (k)
      0: m_sel = 1 - m_sel;
      1: m_freq = (m_freq + 1 > 100) ? 100 : m_freq + 1;
      2: m_freq = (m_freq - 1 < 1) ? 1 : m_freq - 1;
      default: m_phase = (m_phase + 1) % 32;
    endcase
  endfunction

  // Optional short glitches (always shorter than the debounce window),
  // then a clean hold long enough for one event, then a release.
  task automatic press_key(input int k, input int hold, input int gap, input bit bounce);
    int nb;
    if (bounce) begin
      nb = int'($urandom_range(0, 3));
      for (int i = 0; i < nb; i++) begin
        key_in[k] = 1'b0;
        tick(int'($urandom_range(1, 3)));
        key_in[k] = 1'b1;
        tick(int'($urandom_range(1, 3)));
      end
    end
    key_in[k] = 1'b0;
    tick(hold);
    key_in[k] = 1'b1;
    tick(gap);
    model_apply(k);
  endtask

  task automatic test_reset();
    int f0;
    sys_rst_n = 1'b0;
    key_in    = 4'hF;
    tick(3);
    sys_rst_n = 1'b1;
    model_reset();
    tick(1);
    tests_run++;
    if (sel !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_sel: got %0d expected 0", sel);
    end
    tests_run++;
    if (freq !== 7'd1) begin
      tests_failed++;
      $display("FAIL reset_freq: got %0d expected 1", freq);
    end
    tests_run++;
    if (phase_ctrl !== 5'd0) begin
      tests_failed++;
      $display("FAIL reset_phase: got %0d expected 0", phase_ctrl);
    end
    tests_run++;
    if (key_flag !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_flag: got %0d expected 0", key_flag);
    end
    f0 = flag_cnt;
    tick(100);
    tests_run++;
    if (flag_cnt - f0 != 0) begin
      tests_failed++;
      $display("FAIL idle_no_flag: got %0d pulses expected 0", flag_cnt - f0);
    end
  endtask

  task automatic test_bounce();
    int f0, t0, lat;
    f0 = flag_cnt;
    for (int i = 0; i < 5; i++) begin
      key_in[1] = 1'b0;
      tick(3);
      key_in[1] = 1'b1;
      tick(3);
    end
    key_in[1] = 1'b0;
    t0 = cyc;
    tick(30);
    key_in[1] = 1'b1;
    tick(6);
    model_apply(1);
    tests_run++;
    if (flag_cnt - f0 != 1) begin
      tests_failed++;
      $display("FAIL bounce_pulses: got %0d expected 1", flag_cnt - f0);
    end
    lat = (flag_cycles.size() > 0) ? flag_cycles[$] - t0 : -1;
    tests_run++;
    if (lat < LAT - 1 || lat > LAT + 1) begin
      tests_failed++;
      $display("FAIL bounce_latency: got %0d cycles expected %0d +-1", lat, LAT);
    end
    tests_run++;
    if (freq !== 7'(m_freq)) begin
      tests_failed++;
      $display("FAIL bounce_freq: got %0d expected %0d", freq, m_freq);
    end
  endtask

  task automatic test_freq_sat();
    int f0;
    f0 = flag_cnt;
    for (int i = 0; i < 102; i++) begin
      press_key(1, int'($urandom_range(15, 25)), int'($urandom_range(4, 8)), 1'b1);
      tests_run++;
      if (freq !== 7'(m_freq)) begin
        tests_failed++;
        $display("FAIL freq_up[%0d]: got %0d expected %0d", i, freq, m_freq);
      end
    end
    tests_run++;
    if (freq !== FREQ_MAX) begin
      tests_failed++;
      $display("FAIL freq_sat_max: got %0d expected 100", freq);
    end
    tests_run++;
    if (flag_cnt - f0 != 102) begin
      tests_failed++;
      $display("FAIL freq_up_pulses: got %0d expected 102", flag_cnt - f0);
    end
    f0 = flag_cnt;
    for (int i = 0; i < 105; i++) begin
      press_key(2, int'($urandom_range(15, 25)), int'($urandom_range(4, 8)), 1'b1);
      tests_run++;
      if (freq !== 7'(m_freq)) begin
        tests_failed++;
        $display("FAIL freq_dn[%0d]: got %0d expected %0d", i, freq, m_freq);
      end
    end
    tests_run++;
    if (freq !== FREQ_MIN) begin
      tests_failed++;
      $display("FAIL freq_sat_min: got %0d expected 1", freq);
    end
    tests_run++;
    if (flag_cnt - f0 != 105) begin
      tests_failed++;
      $display("FAIL freq_dn_pulses: got %0d expected 105", flag_cnt - f0);
    end
  endtask

  task automatic test_phase_wrap();
    for (int i = 0; i < 33; i++) begin
      press_key(3, int'($urandom_range(15, 25)), int'($urandom_range(4, 8)), 1'b1);
      tests_run++;
      if (phase_ctrl !== 5'(m_phase)) begin
        tests_failed++;
        $display("FAIL phase_step[%0d]: got %0d expected %0d", i, phase_ctrl, m_phase);
      end
    end
    tests_run++;
    if (phase_ctrl !== 5'd1) begin
      tests_failed++;
      $display("FAIL phase_wrap: got %0d expected 1", phase_ctrl);
    end
    for (int i = 0; i < 2; i++) begin
      press_key(0, int'($urandom_range(15, 25)), int'($urandom_range(4, 8)), 1'b0);
      tests_run++;
      if (sel !== 1'(m_sel)) begin
        tests_failed++;
        $display("FAIL sel_toggle[%0d]: got %0d expected %0d", i, sel, m_sel);
      end
    end
  endtask

  task automatic test_simultaneous();
    int f0;
    f0 = flag_cnt;
    key_in = 4'b0110;
    tick(20);
    key_in = 4'hF;
    tick(6);
    model_apply(0);
    tests_run++;
    if (flag_cnt - f0 != 1) begin
      tests_failed++;
      $display("FAIL simul_pulses: got %0d expected 1", flag_cnt - f0);
    end
    tests_run++;
    if (sel !== 1'(m_sel)) begin
      tests_failed++;
      $display("FAIL simul_sel: got %0d expected %0d", sel, m_sel);
    end
    tests_run++;
    if (phase_ctrl !== 5'(m_phase)) begin
      tests_failed++;
      $display("FAIL simul_phase: got %0d expected %0d", phase_ctrl, m_phase);
    end
  endtask

  task automatic test_back_to_back();
    int f0, gap;
    f0 = flag_cnt;
    key_in[1] = 1'b0;
    tick(1);
    key_in[2] = 1'b0;
    tick(20);
    key_in = 4'hF;
    tick(6);
    model_apply(1);
    model_apply(2);
    tests_run++;
    if (flag_cnt - f0 != 2) begin
      tests_failed++;
      $display("FAIL b2b_pulses: got %0d expected 2", flag_cnt - f0);
    end
    gap = (flag_cycles.size() >= 2) ? flag_cycles[$] - flag_cycles[$-1] : -1;
    tests_run++;
    if (gap != 1) begin
      tests_failed++;
      $display("FAIL b2b_spacing: got %0d cycles expected 1", gap);
    end
    tests_run++;
    if (freq !== 7'(m_freq)) begin
      tests_failed++;
      $display("FAIL b2b_freq: got %0d expected %0d", freq, m_freq);
    end
  endtask

  task automatic test_random();
    int f0, k;
    f0 = flag_cnt;
    for (int i = 0; i < 40; i++) begin
      k = int'($urandom_range(0, 3));
      press_key(k, int'($urandom_range(15, 25)), int'($urandom_range(4, 8)), 1'b1);
      tests_run++;
      if (sel !== 1'(m_sel) || freq !== 7'(m_freq) || phase_ctrl !== 5'(m_phase)) begin
        tests_failed++;
        $display("FAIL random[%0d] key%0d: got sel=%0d freq=%0d phase=%0d expected sel=%0d freq=%0d phase=%0d",
                 i, k, sel, freq, phase_ctrl, m_sel, m_freq, m_phase);
      end
    end
    tests_run++;
    if (flag_cnt - f0 != 40) begin
      tests_failed++;
      $display("FAIL random_pulses: got %0d expected 40", flag_cnt - f0);
    end
  endtask

  task automatic test_repeat();
    int f0, exp_evts;
`ifdef AUTO_REPEAT_EN
    exp_evts = 7;
`else
    exp_evts = 1;
`endif
    f0 = flag_cnt;
    key_in[1] = 1'b0;
    tick(92);
    key_in[1] = 1'b1;
    tick(20);
    for (int i = 0; i < exp_evts; i++) model_apply(1);
    tests_run++;
    if (flag_cnt - f0 != exp_evts) begin
      tests_failed++;
      $display("FAIL repeat_pulses: got %0d expected %0d", flag_cnt - f0, exp_evts);
    end
    tests_run++;
    if (freq !== 7'(m_freq)) begin
      tests_failed++;
      $display("FAIL repeat_freq: got %0d expected %0d", freq, m_freq);
    end
  endtask

  task automatic test_reset_mid_hold();
    int f0;
    key_in[2] = 1'b0;
    tick(5);
    sys_rst_n = 1'b0;
    tick(2);
    sys_rst_n = 1'b1;
    model_reset();
    f0 = flag_cnt;
    tick(1);
    tests_run++;
    if (sel !== 1'b0 || freq !== 7'd1 || phase_ctrl !== 5'd0) begin
      tests_failed++;
      $display("FAIL midhold_reset_regs: got sel=%0d freq=%0d phase=%0d expected 0/1/0", sel, freq, phase_ctrl);
    end
    tick(40);
    key_in[2] = 1'b1;
    tick(6);
    tests_run++;
    if (flag_cnt - f0 != 0) begin
      tests_failed++;
      $display("FAIL midhold_no_event: got %0d pulses expected 0", flag_cnt - f0);
    end
    press_key(2, 20, 6, 1'b0);
    tests_run++;
    if (flag_cnt - f0 != 1) begin
      tests_failed++;
      $display("FAIL midhold_repress: got %0d pulses expected 1", flag_cnt - f0);
    end
    tests_run++;
    if (freq !== 7'(m_freq)) begin
      tests_failed++;
      $display("FAIL midhold_freq: got %0d expected %0d", freq, m_freq);
    end
  endtask

  initial begin
    test_reset();
    test_bounce();
    test_freq_sat();
    test_phase_wrap();
    test_simultaneous();
    test_back_to_back();
    test_random();
    test_repeat();
    test_reset_mid_hold();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
